// File: rtl/pwm_brushed_multi.sv
// Multi-channel brushed-motor PWM with per-channel duty ramping and safe
// direction reversal (ramp to zero, dead interval, then new direction).
// One shared period counter; one pwm_brushed_ch instance per H-bridge.

module pwm_brushed_ch #(
   parameter int CNT_W        = 16,
   parameter int RAMP_STEP    = 25,
   parameter int DEAD_PERIODS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bnd_i,
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             duty_wr_i,
   input  logic             ctrl_wr_i,
   input  logic [CNT_W-1:0] wdata_i,
   output logic             pwm_o,
   output logic             dir1_o,
   output logic             dir2_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] duty_o,
   output logic [2:0]       ctrl_o
);
   typedef enum logic [1:0] {RUN = 2'd0, RAMP_DOWN = 2'd1, DEAD = 2'd2} state_e;

   localparam logic [7:0] DEAD_LD = 8'(DEAD_PERIODS);

   logic [CNT_W-1:0] tgt_q, tgt_d, cur_q, cur_d;
   logic             en_q, en_d, dir_q, dir_d, brk_q, brk_d, app_q, app_d;
   state_e           state_q, state_d;
   logic [7:0]       dead_q, dead_d;
   logic             pwm_q, pwm_d, d1_q, d1_d, d2_q, d2_d;
   logic             dir_chg;

   // One ramp step toward tgt, computed one bit wider so nothing wraps.
   function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                             input logic [CNT_W-1:0] tgt);
      logic [CNT_W:0] step, c, t, r;
      step = (CNT_W+1)'(RAMP_STEP);
      c    = {1'b0, cur};
      t    = {1'b0, tgt};
      r    = t;
      if (step != '0) begin
         if (c < t) begin
            r = c + step;
            if (r > t) r = t;
         end else if (c > t) begin
            r = (c < step) ? t : (c - step);
            if (r < t) r = t;
         end
      end
      return r[CNT_W-1:0];
   endfunction

   // State register: bus-visible settings plus FSM and duty state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tgt_q   <= '0;
         en_q    <= 1'b0;
         dir_q   <= 1'b0;
         brk_q   <= 1'b0;
         cur_q   <= '0;
         state_q <= RUN;
         app_q   <= 1'b0;
         dead_q  <= '0;
         pwm_q   <= 1'b0;
         d1_q    <= 1'b0;
         d2_q    <= 1'b0;
      end else begin
         tgt_q   <= tgt_d;
         en_q    <= en_d;
         dir_q   <= dir_d;
         brk_q   <= brk_d;
         cur_q   <= cur_d;
         state_q <= state_d;
         app_q   <= app_d;
         dead_q  <= dead_d;
         pwm_q   <= pwm_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
      end
   end

   // Next state: register writes, then the reversal FSM; duty moves only at boundaries.
   always_comb begin
      tgt_d   = tgt_q;
      en_d    = en_q;
      dir_d   = dir_q;
      brk_d   = brk_q;
      cur_d   = cur_q;
      state_d = state_q;
      app_d   = app_q;
      dead_d  = dead_q;
      dir_chg = ctrl_wr_i && (wdata_i[1] != dir_q);
      if (duty_wr_i) tgt_d = wdata_i;
      if (ctrl_wr_i) begin
         en_d  = wdata_i[0];
         dir_d = wdata_i[1];
         brk_d = wdata_i[2];
      end
      if (!en_q) begin
         // Disabled: park in RUN with the requested direction already applied.
         cur_d   = '0;
         state_d = RUN;
         app_d   = dir_q;
         dead_d  = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (dir_q != app_q) begin
                  if (cur_q != '0) begin
                     state_d = RAMP_DOWN;
                  end else begin
                     state_d = DEAD;
                     dead_d  = DEAD_LD;
                  end
               end else if (bnd_i) begin
                  cur_d = ramp(cur_q, tgt_q);
               end
            end
            RAMP_DOWN: begin
               if (dir_q == app_q) begin
                  state_d = RUN;
                  if (bnd_i) cur_d = ramp(cur_q, tgt_q);
               end else if (bnd_i) begin
                  cur_d = ramp(cur_q, {CNT_W{1'b0}});
                  if (cur_d == '0) begin
                     state_d = DEAD;
                     dead_d  = DEAD_LD;
                  end
               end
            end
            DEAD: begin
               if (dir_chg) begin
                  dead_d = DEAD_LD;
               end else if (bnd_i) begin
                  if (dead_q <= 8'd1) begin
                     // Last dead period done: apply direction and take the first ramp step.
                     state_d = RUN;
                     app_d   = dir_q;
                     cur_d   = ramp({CNT_W{1'b0}}, tgt_q);
                  end else begin
                     dead_d = dead_q - 8'd1;
                  end
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Outputs: PWM compare and H-bridge direction/brake encoding, registered above.
   always_comb begin
      pwm_d = en_q && (state_q != DEAD) && (cnt_i < cur_q);
      if (!en_q) begin
         d1_d = brk_q;
         d2_d = brk_q;
      end else if (state_q == DEAD) begin
         d1_d = 1'b0;
         d2_d = 1'b0;
      end else begin
         d1_d = !app_q;
         d2_d = app_q;
      end
   end

   assign pwm_o  = pwm_q;
   assign dir1_o = d1_q;
   assign dir2_o = d2_q;
   assign busy_o = (state_q != RUN) || (cur_q != tgt_q);
   assign duty_o = tgt_q;
   assign ctrl_o = {brk_q, dir_q, en_q};
endmodule

module pwm_brushed_multi #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 16,
   parameter int DEFAULT_PERIOD = 2499,
   parameter int RAMP_STEP      = 25,
   parameter int DEAD_PERIODS   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic              read,
   output logic [31:0]       readdata,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] direction1,
   output logic [NUM_CH-1:0] direction2
);
   logic [CNT_W-1:0]             cnt_q, cnt_d, per_q, per_d, pact_q, pact_d;
   logic [31:0]                  rdata_q, rdata_d;
   logic                         bnd;
   logic [NUM_CH-1:0]            busy, duty_wr, ctrl_wr;
   logic [NUM_CH-1:0][CNT_W-1:0] duty_tgt;
   logic [NUM_CH-1:0][2:0]       ctrl_rd;
   logic                         unused_wd;

   assign unused_wd = ^writedata[31:CNT_W];
   assign bnd       = (cnt_q == pact_q);

   // Shared counter, period shadow and registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         per_q   <= CNT_W'(DEFAULT_PERIOD);
         pact_q  <= CNT_W'(DEFAULT_PERIOD);
         rdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         pact_q  <= pact_d;
         rdata_q <= rdata_d;
      end
   end

   // Counter wraps at the boundary, which is also where a new period takes effect.
   always_comb begin
      cnt_d  = bnd ? '0 : cnt_q + 1'b1;
      pact_d = bnd ? per_q : pact_q;
      per_d  = (write && address == 4'd0) ? writedata[CNT_W-1:0] : per_q;
   end

   // Read mux; unmapped addresses return zero.
   always_comb begin
      rdata_d = rdata_q;
      if (read) begin
         rdata_d = '0;
         if (address == 4'd0) rdata_d[CNT_W-1:0]  = per_q;
         if (address == 4'd1) rdata_d[NUM_CH-1:0] = busy;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (address == 4'(2 + 2*ch)) rdata_d[CNT_W-1:0] = duty_tgt[ch];
            if (address == 4'(3 + 2*ch)) rdata_d[2:0]       = ctrl_rd[ch];
         end
      end
   end

   assign readdata = rdata_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign duty_wr[g] = write && (address == 4'(2 + 2*g));
      assign ctrl_wr[g] = write && (address == 4'(3 + 2*g));
      pwm_brushed_ch #(
         .CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP), .DEAD_PERIODS(DEAD_PERIODS)
      ) u_ch (
         .clk(clk), .rst(reset), .bnd_i(bnd), .cnt_i(cnt_q),
         .duty_wr_i(duty_wr[g]), .ctrl_wr_i(ctrl_wr[g]),
         .wdata_i(writedata[CNT_W-1:0]),
         .pwm_o(pwm_out[g]), .dir1_o(direction1[g]), .dir2_o(direction2[g]),
         .busy_o(busy[g]), .duty_o(duty_tgt[g]), .ctrl_o(ctrl_rd[g])
      );
   end
endmodule

// File: tb/tb_pwm_brushed_multi.sv
// Directed bench: register-map vector table plus hand-written multi-period
// sequences. u_dut0 jumps to target (RAMP_STEP=0), u_dut1 ramps by 25.

module tb_pwm_brushed_multi;
   logic        clk = 1'b0;
   logic        reset, write, read;
   logic [3:0]  address;
   logic [31:0] writedata, rd0, rd1;
   logic [3:0]  pwm0, pwm1, d1a, d2a, d1b, d2b;
   int          checks = 0, failures = 0, cyc = 0, glitch = 0;
   logic        mon_fwd = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Watches u_dut1 ch0 direction lines while they must hold forward.
   always @(negedge clk)
      if (mon_fwd && (d1b[0] !== 1'b1 || d2b[0] !== 1'b0)) glitch <= glitch + 1;

   pwm_brushed_multi #(.RAMP_STEP(0)) u_dut0 (
      .clk(clk), .reset(reset), .address(address), .write(write),
      .writedata(writedata), .read(read), .readdata(rd0),
      .pwm_out(pwm0), .direction1(d1a), .direction2(d2a));
   pwm_brushed_multi u_dut1 (
      .clk(clk), .reset(reset), .address(address), .write(write),
      .writedata(writedata), .read(read), .readdata(rd1),
      .pwm_out(pwm1), .direction1(d1b), .direction2(d2b));

   typedef struct {
      logic [3:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk); address = a; writedata = d; write = 1'b1;
      @(negedge clk); write = 1'b0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] r0, output logic [31:0] r1);
      @(negedge clk); address = a; read = 1'b1;
      @(negedge clk); read = 1'b0; r0 = rd0; r1 = rd1;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic bit pv(input int w, input int ch);
      return (w != 0) ? pwm1[ch] : pwm0[ch];
   endfunction

   // Next complete high pulse: its length and the cycle it rose; -1 on timeout.
   task automatic meas(input int w, input int ch, output int len, output int rise);
      int n = 0;
      len = -1; rise = -1;
      while (pv(w, ch) && n < 6000) begin @(negedge clk); n++; end
      while (!pv(w, ch) && n < 6000) begin @(negedge clk); n++; end
      if (n >= 6000) return;
      rise = cyc; len = 0;
      while (pv(w, ch) && n < 12000) begin len++; @(negedge clk); n++; end
   endtask

   initial begin
      vec_t        tbl[13];
      logic [31:0] r0, r1;
      int          len, ra, rb, lows0, lows1, k;
      int          exp2[5] = '{25, 50, 75, 100, 100};

      reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {8'd0, pwm0, d1a, d2a, pwm1, d1b, d2b}, 32'd0);
      chk("reset_readdata", rd0 | rd1, 32'd0);
      reset = 1'b0;

      // Register map: {address, write?, write data, expected read-back}
      tbl = '{
         '{4'd0,  1'b0, 32'd0,          32'd2499},
         '{4'd1,  1'b0, 32'd0,          32'd0},
         '{4'd2,  1'b0, 32'd0,          32'd0},
         '{4'd9,  1'b0, 32'd0,          32'd0},
         '{4'd10, 1'b1, 32'h0000FFFF,   32'd0},
         '{4'd15, 1'b1, 32'h00000001,   32'd0},
         '{4'd0,  1'b1, 32'd9,          32'd9},
         '{4'd2,  1'b1, 32'd4,          32'd4},
         '{4'd4,  1'b1, 32'h00012345,   32'h2345},
         '{4'd9,  1'b1, 32'hFFFFFFFA,   32'd2},
         '{4'd7,  1'b1, 32'd5,          32'd5},
         '{4'd7,  1'b1, 32'd0,          32'd0},
         '{4'd0,  1'b1, 32'hABCD0013,   32'h13}
      };
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].wdata);
         bus_rd(tbl[i].addr, r0, r1);
         chk($sformatf("regmap[%0d]_dut0", i), r0, tbl[i].exp);
         chk($sformatf("regmap[%0d]_dut1", i), r1, tbl[i].exp);
      end

      // No ramp, PERIOD=9, duty 4: 4 high clocks per 10.
      do_reset();
      bus_wr(4'd0, 32'd9); bus_wr(4'd2, 32'd4); bus_wr(4'd3, 32'd1);
      bus_rd(4'd1, r0, r1);
      chk("t1_status_busy", r0, 32'd1);
      meas(0, 0, len, ra);
      chk("t1_high_a", len, 32'd4);
      meas(0, 0, len, rb);
      chk("t1_high_b", len, 32'd4);
      chk("t1_period", rb - ra, 32'd10);
      chk("t1_dir", {d1a[0], d2a[0]}, 32'd2);
      bus_rd(4'd1, r0, r1);
      chk("t1_status_idle", r0, 32'd0);

      // Ramp by 25 on ch1 at PERIOD=2499.
      do_reset();
      bus_wr(4'd4, 32'd100); bus_wr(4'd5, 32'd1);
      for (int i = 0; i < 5; i++) begin
         meas(1, 1, len, ra);
         chk($sformatf("t2_high[%0d]", i), len, exp2[i]);
         if (i == 1) begin bus_rd(4'd1, r0, r1); chk("t2_status_busy", r1, 32'd2); end
         if (i == 3) begin bus_rd(4'd1, r0, r1); chk("t2_status_done", r1, 32'd0); end
      end

      // ch0 at duty 100, PERIOD=199; reversal aborted mid ramp-down.
      do_reset();
      bus_wr(4'd0, 32'd199); bus_wr(4'd2, 32'd100); bus_wr(4'd3, 32'd1);
      for (int i = 0; i < 4; i++) begin
         meas(1, 0, len, ra);
         chk($sformatf("t4_rampup[%0d]", i), len, 32'(25 * (i + 1)));
      end
      mon_fwd = 1'b1;
      bus_wr(4'd3, 32'd3);
      meas(1, 0, len, ra);
      chk("t4_rampdown_75", len, 32'd75);
      bus_rd(4'd1, r0, r1);
      chk("t4_status_rampdown", r1, 32'd1);
      bus_wr(4'd3, 32'd1);
      meas(1, 0, len, ra);
      chk("t4_back_to_100", len, 32'd100);
      mon_fwd = 1'b0;
      chk("t4_dir_held_10", glitch, 32'd0);

      // Full reversal: ramp down, 4 dead periods, reverse and ramp up.
      bus_wr(4'd3, 32'd3);
      meas(1, 0, len, ra); chk("t3_down_75", len, 32'd75);
      meas(1, 0, len, ra); chk("t3_down_50", len, 32'd50);
      meas(1, 0, len, ra); chk("t3_down_25", len, 32'd25);
      repeat (300) @(negedge clk);
      chk("t3_dead_lines", {pwm1[0], d1b[0], d2b[0]}, 32'd0);
      meas(1, 0, len, rb);
      chk("t3_up_25", len, 32'd25);
      chk("t3_dead_span", rb - ra, 32'd1000);
      chk("t3_reverse_lines", {d1b[0], d2b[0]}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         meas(1, 0, len, ra);
         chk($sformatf("t3_up[%0d]", i), len, 32'(50 + 25 * i));
      end

      // Disable with brake, then duty above the period.
      bus_wr(4'd3, 32'd4);
      @(negedge clk);
      chk("t5_brake_dut1", {pwm1[0], d1b[0], d2b[0]}, 32'd3);
      chk("t5_brake_dut0", {pwm0[0], d1a[0], d2a[0]}, 32'd3);
      bus_wr(4'd2, 32'd204); bus_wr(4'd3, 32'd1);
      repeat (2400) @(negedge clk);
      lows0 = 0; lows1 = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pwm0[0] !== 1'b1) lows0++;
         if (pwm1[0] !== 1'b1) lows1++;
      end
      chk("t5_const_high_dut0", lows0, 32'd0);
      chk("t5_const_high_dut1", lows1, 32'd0);

      // PERIOD change mid-period waits for the boundary.
      bus_wr(4'd2, 32'd10);
      meas(0, 0, len, ra);
      chk("t6_high_old", len, 32'd10);
      bus_wr(4'd0, 32'd19);
      meas(0, 0, len, rb);
      chk("t6_old_period", rb - ra, 32'd200);
      meas(0, 0, len, ra);
      chk("t6_new_period", ra - rb, 32'd20);
      chk("t6_high_new", len, 32'd10);

      // Reversal on dut1, then asynchronous reset while in DEAD.
      bus_wr(4'd3, 32'd3);
      k = 0;
      while (!(d1b[0] === 1'b0 && d2b[0] === 1'b0) && k < 3000) begin @(negedge clk); k++; end
      chk("t6_reached_dead", k < 3000, 32'd1);
      bus_rd(4'd1, r0, r1);
      chk("t6_status_dead", r1[0], 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_reset_outputs", {8'd0, pwm0, d1a, d2a, pwm1, d1b, d2b}, 32'd0);
      chk("t6_async_reset_readdata", rd0 | rd1, 32'd0);
      @(negedge clk); reset = 1'b0;
      bus_rd(4'd0, r0, r1);
      chk("t6_period_default_dut0", r0, 32'd2499);
      chk("t6_period_default_dut1", r1, 32'd2499);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
